// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate generator with a valid/ready handshake on
// both sides. The pipeline holds an output register plus one skid entry, so
// it can sustain one item per cycle and still give in_ready straight from a
// flop. It also keeps a saturating count of accepted illegal opcodes.
//
// Optional feature macro: IMM_GEN_UJ_EN
//   defined   -> LUI/AUIPC decode as U-type and JAL decodes as J-type
//   undefined -> those three opcodes are illegal and are counted
module imm_gen_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int WORD_WIDTH = 32,
  parameter int TAG_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_instr,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [2:0]            out_fmt,
  output logic                  out_illegal,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic [CNT_WIDTH-1:0]  illegal_count
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] imm;
    fmt_e                  fmt;
    logic                  illegal;
    logic [TAG_WIDTH-1:0]  tag;
  } entry_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [31:0] w_instr;
  logic [31:0] w_imm32;
  entry_t      w_dec;
  logic        w_acc;
  logic        w_drain;
  logic        w_skid_next;

  entry_t                 r_out;
  entry_t                 r_skid;
  logic                   r_out_valid;
  logic                   r_skid_valid;
  logic                   r_in_ready;
  logic [CNT_WIDTH-1:0]   r_cnt;

  // Only the low 32 bits of the instruction word carry an encoding.
  assign w_instr = in_instr[31:0];

`ifndef IMM_GEN_UJ_EN
  // Bits [19:12] only feed the U/J immediates, which are not built here.
  logic w_unused_bits;
  assign w_unused_bits = ^w_instr[19:12];
`endif

  // Decode the incoming word into a 32-bit immediate, its format and the
  // illegal flag; the immediate is then sign-extended to DATA_WIDTH.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    w_imm32     = '0;
    w_dec       = '0;
    w_dec.fmt   = FMT_NONE;
    w_dec.tag   = in_tag;
    unique case (w_instr[6:0])
      OP_LOAD, OP_IMM, OP_JALR: begin
        w_imm32   = 32'($signed(w_instr[31:20]));
        w_dec.fmt = FMT_I;
      end
      OP_STORE: begin
        w_imm32   = 32'($signed({w_instr[31:25], w_instr[11:7]}));
        w_dec.fmt = FMT_S;
      end
      OP_BRANCH: begin
        w_imm32   = 32'($signed({w_instr[31], w_instr[7], w_instr[30:25],
                                 w_instr[11:8], 1'b0}));
        w_dec.fmt = FMT_B;
      end
`ifdef IMM_GEN_UJ_EN
      OP_LUI, OP_AUIPC: begin
        w_imm32   = {w_instr[31:12], 12'b0};
        w_dec.fmt = FMT_U;
      end
      OP_JAL: begin
        w_imm32   = 32'($signed({w_instr[31], w_instr[19:12], w_instr[20],
                                 w_instr[30:21], 1'b0}));
        w_dec.fmt = FMT_J;
      end
`endif
      default: begin
        w_dec.illegal = 1'b1;
      end
    endcase
    w_dec.imm = DATA_WIDTH'($signed(w_imm32));
  end

  assign w_acc   = in_valid & r_in_ready;
  assign w_drain = r_out_valid & out_ready;

  // Skid occupancy after this edge: a full skid empties on a drain; an empty
  // skid fills when an input arrives while the output is stalled.
  always_comb begin
    w_skid_next = 1'b0;
    if (r_skid_valid) begin
      w_skid_next = ~w_drain;
    end else begin
      w_skid_next = r_out_valid & ~out_ready & w_acc;
    end
  end

  // Output register, skid entry, registered in_ready and illegal counter.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
      r_cnt        <= '0;
    end else begin
      if (!r_out_valid || w_drain) begin
        if (r_skid_valid) begin
          r_out       <= r_skid;
          r_out_valid <= 1'b1;
        end else if (w_acc) begin
          r_out       <= w_dec;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (w_acc) begin
        r_skid <= w_dec;
      end
      r_skid_valid <= w_skid_next;
      r_in_ready   <= ~w_skid_next;
      if (w_acc && w_dec.illegal && (r_cnt != {CNT_WIDTH{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign out_imm       = r_out.imm;
  assign out_fmt       = r_out.fmt;
  assign out_illegal   = r_out.illegal;
  assign out_tag       = r_out.tag;
  assign illegal_count = r_cnt;

endmodule
